// File: rtl/branch_predict_resolve_pkg.sv
// branch_predict_resolve_pkg: counter encodings, default sizes and the 2-bit saturating step
package branch_predict_resolve_pkg;
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctrState;
   localparam int DEF_IDX_BITS = 4;
   localparam int DEF_STAT_W = 16;
   function automatic logic [1:0] satStep(input logic [1:0] cur, input logic up);
      return up ? (cur == ST ? cur : cur + 2'd1) : (cur == SNT ? cur : cur - 2'd1);
   endfunction
endpackage

// File: rtl/branch_predict_resolve_if.sv
// branch_predict_resolve_if: IF lookup and resolve-stage signals between pipeline and predictor
interface branch_predict_resolve_if #(
   parameter int WIDTH = 32,
   parameter int STAT_W = 16
);
   logic              if_pc_valid_unused;
   logic [WIDTH-1:0]  if_pc;
   logic              if_is_branch;
   logic              pred_taken;
   logic              rs_valid;
   logic [WIDTH-1:0]  rs_pc;
   logic [WIDTH-1:0]  rs_busA;
   logic              rs_branch;
   logic              rs_branch_zero;
   logic              rs_jump;
   logic              rs_pred_taken;
   logic              stall;
   logic              redirect_valid;
   logic              redirect_taken;
   logic              leap;
   logic [STAT_W-1:0] branch_count;
   logic [STAT_W-1:0] mispred_count;
   modport master (
      output if_pc, if_is_branch, rs_valid, rs_pc, rs_busA, rs_branch, rs_branch_zero,
             rs_jump, rs_pred_taken, stall,
      input  pred_taken, redirect_valid, redirect_taken, leap, branch_count, mispred_count
   );
   modport slave (
      input  if_pc, if_is_branch, rs_valid, rs_pc, rs_busA, rs_branch, rs_branch_zero,
             rs_jump, rs_pred_taken, stall,
      output pred_taken, redirect_valid, redirect_taken, leap, branch_count, mispred_count
   );
endinterface

// File: rtl/branch_predict_resolve_sat_counter2.sv
// sat_counter2: next-state logic of a 2-bit up/down saturating counter
module sat_counter2
   import branch_predict_resolve_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       up,
   output logic [1:0] nxt
);
   always_comb nxt = satStep(cur, up);
endmodule

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: BHT lookup in IF, BEQZ/BNEZ/jump resolve with registered redirect and stats
module branch_predict_resolve
   import branch_predict_resolve_pkg::*;
#(
   parameter int         WIDTH = 32,
   parameter int         IDX_BITS = DEF_IDX_BITS,
   parameter logic [1:0] CTR_INIT = 2'(WNT),
   parameter int         STAT_W = DEF_STAT_W
) (
   input logic clk,
   input logic reset,
   branch_predict_resolve_if.slave bus
);
   localparam int ENTRIES = 2 ** IDX_BITS;
   logic [1:0]          bht [ENTRIES];
   logic [IDX_BITS-1:0] rdIdx, wrIdx;
   logic [1:0]          curCtr, nxtCtr;
   logic                zero, cond, actual, res, upd, mispred;
   logic                unusedPcBits;
   assign rdIdx = bus.if_pc[IDX_BITS+1:2];
   assign wrIdx = bus.rs_pc[IDX_BITS+1:2];
   assign unusedPcBits = ^{bus.if_pc[WIDTH-1:IDX_BITS+2], bus.if_pc[1:0],
                           bus.rs_pc[WIDTH-1:IDX_BITS+2], bus.rs_pc[1:0]};
   assign bus.pred_taken = bus.if_is_branch & bht[rdIdx][1];
   // a jump wins over a simultaneous branch flag, so branch-only paths mask it out
   always_comb begin
      zero    = bus.rs_busA == '0;
      cond    = bus.rs_branch & (bus.rs_branch_zero ? zero : ~zero);
      actual  = cond | bus.rs_jump;
      res     = bus.rs_valid & ~bus.stall & (bus.rs_branch | bus.rs_jump);
      upd     = res & bus.rs_branch & ~bus.rs_jump;
      mispred = bus.rs_jump ? ~bus.rs_pred_taken : (bus.rs_branch & (actual != bus.rs_pred_taken));
      curCtr  = bht[wrIdx];
   end
   sat_counter2 uCtr (.cur(curCtr), .up(cond), .nxt(nxtCtr));
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_INIT;
      end else if (upd) begin
         bht[wrIdx] <= nxtCtr;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.redirect_valid <= 1'b0;
         bus.redirect_taken <= 1'b0;
         bus.leap           <= 1'b0;
      end else begin
         bus.redirect_valid <= res & mispred;
         if (res) begin
            bus.redirect_taken <= actual;
            bus.leap           <= actual;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.branch_count  <= '0;
         bus.mispred_count <= '0;
      end else if (upd) begin
         if (~&bus.branch_count) bus.branch_count <= bus.branch_count + STAT_W'(1);
         if (mispred && ~&bus.mispred_count) bus.mispred_count <= bus.mispred_count + STAT_W'(1);
      end
   end
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: directed checks of lookup, resolve, training, saturation and reset
module tb_branch_predict_resolve;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;
   branch_predict_resolve_if #(.WIDTH(32), .STAT_W(4)) bus ();
   branch_predict_resolve #(.WIDTH(32), .IDX_BITS(4), .CTR_INIT(2'b01), .STAT_W(4)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) assert (!(bus.rs_jump && bus.rs_branch));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic resolve(input logic [31:0] pc, input logic [31:0] a, input logic br,
                          input logic bz, input logic jmp, input logic pt);
      bus.rs_valid = 1'b1; bus.rs_pc = pc; bus.rs_busA = a; bus.rs_branch = br;
      bus.rs_branch_zero = bz; bus.rs_jump = jmp; bus.rs_pred_taken = pt;
   endtask
   task automatic idle();
      bus.rs_valid = 1'b0; bus.rs_branch = 1'b0; bus.rs_jump = 1'b0; bus.stall = 1'b0;
   endtask
   task automatic outs(input string tag, input logic rv, input logic rt, input logic lp,
                       input logic [3:0] bc, input logic [3:0] mc);
      chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(rv));
      chk({tag, ".redirect_taken"}, 32'(bus.redirect_taken), 32'(rt));
      chk({tag, ".leap"}, 32'(bus.leap), 32'(lp));
      chk({tag, ".branch_count"}, 32'(bus.branch_count), 32'(bc));
      chk({tag, ".mispred_count"}, 32'(bus.mispred_count), 32'(mc));
   endtask
   task automatic look(input string tag, input logic [31:0] pc, input logic exp);
      bus.if_pc = pc; bus.if_is_branch = 1'b1;
      #1;
      chk(tag, 32'(bus.pred_taken), 32'(exp));
   endtask
   initial begin
      reset = 1'b1;
      bus.if_pc = '0; bus.if_is_branch = 1'b0; bus.rs_pc = '0; bus.rs_busA = '0;
      bus.rs_branch_zero = 1'b0; bus.rs_pred_taken = 1'b0;
      idle();
      tick(); tick();
      reset = 1'b0;
      outs("reset", 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) look("reset_lookup", 32'(i) << 2, 1'b0);
      // BEQZ taken, predicted not taken
      resolve(32'h40, 0, 1, 1, 0, 0);
      tick(); idle();
      outs("beqz_mispred", 1, 1, 1, 1, 1);
      look("beqz_trained", 32'h40, 1'b1);
      tick();
      outs("pulse_end", 0, 1, 1, 1, 1);
      // BNEZ taken three times saturates to 11
      resolve(32'h40, 5, 1, 0, 0, 1);
      tick(); tick(); tick(); idle();
      outs("bnez_x3", 0, 1, 1, 4, 1);
      resolve(32'h40, 0, 1, 0, 0, 1);
      tick(); idle();
      outs("bnez_not_taken", 1, 0, 0, 5, 2);
      look("ctr_11_to_10", 32'h40, 1'b1);
      resolve(32'h40, 0, 1, 0, 0, 1);
      tick(); idle();
      look("ctr_10_to_01", 32'h40, 1'b0);
      outs("bnez_again", 1, 0, 0, 6, 3);
      // jumps redirect but never train or count
      resolve(32'h40, 0, 0, 0, 1, 0);
      tick(); idle();
      outs("jal", 1, 1, 1, 6, 3);
      look("jal_no_train", 32'h40, 1'b0);
      resolve(32'h40, 0, 0, 0, 1, 0); bus.stall = 1'b1;
      tick();
      outs("jal_stall", 0, 1, 1, 6, 3);
      resolve(32'h40, 0, 1, 0, 0, 1); bus.stall = 1'b1;
      tick(); idle();
      outs("bnez_stall", 0, 1, 1, 6, 3);
      look("stall_no_train", 32'h40, 1'b0);
      resolve(32'h40, 0, 0, 0, 1, 1);
      tick(); idle();
      outs("jal_predicted", 0, 1, 1, 6, 3);
      // same-index update and lookup: old value now, new value next cycle
      resolve(32'h0C, 0, 1, 1, 0, 0);
      look("same_idx_old", 32'h0C, 1'b0);
      tick(); idle();
      look("same_idx_new", 32'h0C, 1'b1);
      look("alias_idx3", 32'h4C, 1'b1);
      bus.if_is_branch = 1'b0;
      #1 chk("not_branch", 32'(bus.pred_taken), 32'd0);
      outs("same_idx", 1, 1, 1, 7, 4);
      resolve(32'h80, 0, 1, 1, 0, 1);
      bus.rs_valid = 1'b0;
      tick();
      outs("invalid", 0, 1, 1, 7, 4);
      // saturation of both stat counters
      resolve(32'h80, 0, 1, 1, 0, 1);
      for (int i = 0; i < 9; i++) tick();
      idle();
      outs("branch_sat", 0, 1, 1, 15, 4);
      resolve(32'h84, 7, 1, 1, 0, 1);
      for (int i = 0; i < 12; i++) tick();
      idle();
      outs("mispred_sat", 1, 0, 0, 15, 15);
      tick();
      // reset drops a pending redirect and re-initialises the BHT
      resolve(32'h0C, 0, 1, 1, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0; idle();
      outs("mid_reset", 0, 0, 0, 0, 0);
      look("reset_bht_0", 32'h40, 1'b0);
      look("reset_bht_3", 32'h0C, 1'b0);
      look("reset_bht_2", 32'h88, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
